// File: rtl/switch_allocator_pkg.sv
// Shared types and helpers for the switch allocator.
//   N            : port count, taken from config.sv
//   PW           : port-index width, taken from config.sv
//   lock_state_e : per-output lock FSM state (IDLE / LOCKED)
//   port_idx_t   : port index type
//   next_idx()   : index + 1 modulo N (wraps N-1 to 0)
`include "config.sv"

package switch_allocator_pkg;

    localparam int N  = `N;
    localparam int PW = `PORT_W;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    typedef logic [PW-1:0] port_idx_t;

    // Round-robin successor of a port index; N is not a power of two in
    // general, so the wrap is explicit rather than relying on overflow.
    function automatic port_idx_t next_idx(input port_idx_t idx);
        port_idx_t nxt;
        if (idx == port_idx_t'(N - 1)) begin
            nxt = port_idx_t'(0);
        end else begin
            nxt = idx + port_idx_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/config.sv
// Shared build configuration for the switch allocator slice.
//   N      : number of router ports (inputs == outputs).
//   PORT_W : width of a port index, must equal $clog2(N).
`ifndef SWITCH_ALLOCATOR_CONFIG_SV
`define SWITCH_ALLOCATOR_CONFIG_SV
`define N 5
`define PORT_W 3
`endif

// File: rtl/switch_allocator_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter for one output.
//   req : per-input request vector (bit i = input i)
//   ptr : highest-priority input index this cycle (must be < N)
//   en  : arbitration enable; when low no grant is produced
//   gnt : one-hot grant vector (all zero when nothing is granted)
//   idx : index of the granted input (zero when nothing is granted)
module rr_arbiter
    import switch_allocator_pkg::*;
(
    input  logic [N-1:0] req,
    input  port_idx_t    ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output port_idx_t    idx
);

    port_idx_t cand_s;
    logic      found_s;

    // Scan ptr, ptr+1, ... mod N and grant the first requester found.
    always_comb begin
        gnt     = {N{1'b0}};
        idx     = port_idx_t'(0);
        found_s = 1'b0;
        cand_s  = ptr;
        for (int k = 0; k < N; k++) begin
            if (en && !found_s && req[cand_s]) begin
                gnt[cand_s] = 1'b1;
                idx         = cand_s;
                found_s     = 1'b1;
            end else begin
                found_s = found_s;
            end
            cand_s = next_idx(cand_s);
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin switch allocation with optional
// wormhole locking. Grants are combinational (same cycle as the request);
// lock state and round-robin pointers update on the next rising edge.
//   clk          : clock
//   reset_n      : asynchronous active-low reset; forces all outputs to 0
//   i_output_req : per input, requested output (multi-hot reduced to lowest)
//   i_valid      : per input, flit present
//   i_tail       : per input, current flit is a tail
//   i_out_ready  : per output, downstream can accept a flit
//   o_grant      : per input, flit forwarded this cycle
//   o_xbar_sel   : per output, winning input index (0 when idle)
//   o_out_valid  : per output, a flit is forwarded this cycle
//   LOCK_EN      : 1 = hold an output for the whole packet, 0 = per flit
`include "config.sv"

module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter bit LOCK_EN = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [0:`N-1][0:`N-1]             i_output_req,
    input  logic [0:`N-1]                     i_valid,
    input  logic [0:`N-1]                     i_tail,
    input  logic [0:`N-1]                     i_out_ready,
    output logic [0:`N-1]                     o_grant,
    output logic [0:`N-1][$clog2(`N)-1:0]     o_xbar_sel,
    output logic [0:`N-1]                     o_out_valid
);

    // dest_s[i][o]    : input i effectively requests output o (one-hot)
    // col_req_s[o][i] : same information seen from the output side
    logic [N-1:0] dest_s    [N];
    logic [N-1:0] col_req_s [N];
    logic [N-1:0] arb_req_s [N];
    logic [N-1:0] arb_gnt_s [N];
    port_idx_t    arb_idx_s [N];
    logic         arb_en_s  [N];
    logic         taken_s;

    lock_state_e  state_r [N];
    port_idx_t    ptr_r   [N];
    port_idx_t    owner_r [N];

    // Qualify requests with valid and keep only the lowest requested output.
    always_comb begin
        taken_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            dest_s[i] = {N{1'b0}};
            taken_s   = 1'b0;
            for (int o = 0; o < N; o++) begin
                if (i_valid[i] && i_output_req[i][o] && !taken_s) begin
                    dest_s[i][o] = 1'b1;
                    taken_s      = 1'b1;
                end else begin
                    taken_s = taken_s;
                end
            end
        end
    end

    // Transpose to per-output request vectors; a locked output only sees
    // its owner, so the arbiter can never pick anyone else.
    always_comb begin
        for (int o = 0; o < N; o++) begin
            for (int i = 0; i < N; i++) begin
                col_req_s[o][i] = dest_s[i][o];
            end
            case (state_r[o])
                ST_IDLE:   arb_req_s[o] = col_req_s[o];
                ST_LOCKED: arb_req_s[o] = col_req_s[o] &
                                          ({{(N-1){1'b0}}, 1'b1} << owner_r[o]);
                default:   arb_req_s[o] = {N{1'b0}};
            endcase
            // Holding reset_n here keeps every grant low during reset.
            arb_en_s[o] = i_out_ready[o] && reset_n;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_arb
        rr_arbiter u_rr_arbiter (
            .req (arb_req_s[g]),
            .ptr (ptr_r[g]),
            .en  (arb_en_s[g]),
            .gnt (arb_gnt_s[g]),
            .idx (arb_idx_s[g])
        );
    end

    // Collect per-output grants into input grants and crossbar selects.
    always_comb begin
        o_grant     = {N{1'b0}};
        o_out_valid = {N{1'b0}};
        o_xbar_sel  = {(N*PW){1'b0}};
        for (int o = 0; o < N; o++) begin
            if (|arb_gnt_s[o]) begin
                o_out_valid[o] = 1'b1;
                o_xbar_sel[o]  = arb_idx_s[o];
            end else begin
                o_xbar_sel[o]  = port_idx_t'(0);
            end
            for (int i = 0; i < N; i++) begin
                o_grant[i] = o_grant[i] | arb_gnt_s[o][i];
            end
        end
    end

    // Per-output lock FSM and round-robin pointer update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int o = 0; o < N; o++) begin
                state_r[o] <= ST_IDLE;
                ptr_r[o]   <= port_idx_t'(0);
                owner_r[o] <= port_idx_t'(0);
            end
        end else begin
            for (int o = 0; o < N; o++) begin
                case (state_r[o])
                    ST_IDLE: begin
                        if (|arb_gnt_s[o]) begin
                            ptr_r[o] <= next_idx(arb_idx_s[o]);
                            if (LOCK_EN && !i_tail[arb_idx_s[o]]) begin
                                state_r[o] <= ST_LOCKED;
                                owner_r[o] <= arb_idx_s[o];
                            end else begin
                                state_r[o] <= ST_IDLE;
                            end
                        end else begin
                            state_r[o] <= ST_IDLE;
                        end
                    end
                    ST_LOCKED: begin
                        // Pointer stays where the head grant left it.
                        if ((|arb_gnt_s[o]) && i_tail[owner_r[o]]) begin
                            state_r[o] <= ST_IDLE;
                        end else begin
                            state_r[o] <= ST_LOCKED;
                        end
                    end
                    default: begin
                        state_r[o] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed, table-driven bench for switch_allocator (N = 5, LOCK_EN = 1).
module tb_switch_allocator;
    import switch_allocator_pkg::*;

    logic                    clk;
    logic                    reset_n;
    logic [0:N-1][0:N-1]     i_output_req;
    logic [0:N-1]            i_valid;
    logic [0:N-1]            i_tail;
    logic [0:N-1]            i_out_ready;
    logic [0:N-1]            o_grant;
    logic [0:N-1][PW-1:0]    o_xbar_sel;
    logic [0:N-1]            o_out_valid;

    int checks = 0;
    int errors = 0;

    // Request rows: leftmost bit is output 0.
    localparam logic [0:N-1] Z  = 5'b00000;
    localparam logic [0:N-1] R0 = 5'b10000;
    localparam logic [0:N-1] R1 = 5'b01000;
    localparam logic [0:N-1] R2 = 5'b00100;
    localparam logic [0:N-1] R3 = 5'b00010;
    localparam logic [0:N-1] R4 = 5'b00001;
    localparam logic [0:N-1][PW-1:0] SEL0 = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

    typedef struct packed {
        logic [0:N-1]         valid;
        logic [0:N-1]         tail;
        logic [0:N-1]         ready;
        logic [0:N-1][0:N-1]  req;
        logic [0:N-1]         eg;
        logic [0:N-1]         eov;
        logic [0:N-1][PW-1:0] esel;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    switch_allocator #(.LOCK_EN(1'b1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_output_req (i_output_req),
        .i_valid      (i_valid),
        .i_tail       (i_tail),
        .i_out_ready  (i_out_ready),
        .o_grant      (o_grant),
        .o_xbar_sel   (o_xbar_sel),
        .o_out_valid  (o_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [0:N-1] v, input logic [0:N-1] t,
                                input logic [0:N-1] r, input logic [0:N-1][0:N-1] q,
                                input logic [0:N-1] g, input logic [0:N-1] ov,
                                input logic [0:N-1][PW-1:0] s);
        vec_t x;
        x.valid = v; x.tail = t; x.ready = r; x.req = q;
        x.eg = g; x.eov = ov; x.esel = s;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [0:N-1] v, input logic [0:N-1] t,
                         input logic [0:N-1] r, input logic [0:N-1][0:N-1] q);
        i_valid = v; i_tail = t; i_out_ready = r; i_output_req = q;
    endtask

    task automatic chk_out(input string tag, input logic [0:N-1] g,
                           input logic [0:N-1] ov, input logic [0:N-1][PW-1:0] s);
        chk({tag, "_grant"},     64'(o_grant),     64'(g));
        chk({tag, "_out_valid"}, 64'(o_out_valid), 64'(ov));
        chk({tag, "_xbar_sel"},  64'(o_xbar_sel),  64'(s));
    endtask

    initial begin
        // Round-robin on output 2: winners 0,1,3,0.
        vecs[0]  = mk(5'b11010, 5'b11111, 5'b11111, {R2, R2, Z, R2, Z}, 5'b10000, 5'b00100, SEL0);
        vecs[1]  = mk(5'b11010, 5'b11111, 5'b11111, {R2, R2, Z, R2, Z}, 5'b01000, 5'b00100, {3'd0, 3'd0, 3'd1, 3'd0, 3'd0});
        vecs[2]  = mk(5'b11010, 5'b11111, 5'b11111, {R2, R2, Z, R2, Z}, 5'b00010, 5'b00100, {3'd0, 3'd0, 3'd3, 3'd0, 3'd0});
        vecs[3]  = mk(5'b11010, 5'b11111, 5'b11111, {R2, R2, Z, R2, Z}, 5'b10000, 5'b00100, SEL0);
        // Move ptr[4] to 1, then a 3-flit packet from input 1 locks output 4.
        vecs[4]  = mk(5'b10000, 5'b10000, 5'b11111, {R4, Z, Z, Z, Z}, 5'b10000, 5'b00001, SEL0);
        vecs[5]  = mk(5'b11000, 5'b10000, 5'b11111, {R4, R4, Z, Z, Z}, 5'b01000, 5'b00001, {3'd0, 3'd0, 3'd0, 3'd0, 3'd1});
        vecs[6]  = mk(5'b11000, 5'b10000, 5'b11111, {R4, R4, Z, Z, Z}, 5'b01000, 5'b00001, {3'd0, 3'd0, 3'd0, 3'd0, 3'd1});
        vecs[7]  = mk(5'b11000, 5'b11000, 5'b11111, {R4, R4, Z, Z, Z}, 5'b01000, 5'b00001, {3'd0, 3'd0, 3'd0, 3'd0, 3'd1});
        vecs[8]  = mk(5'b10000, 5'b10000, 5'b11111, {R4, Z, Z, Z, Z}, 5'b10000, 5'b00001, SEL0);
        // Backpressure on output 3, then ready: 2 wins, then 4.
        vecs[9]  = mk(5'b00101, 5'b11111, 5'b11101, {Z, Z, R3, Z, R3}, 5'b00000, 5'b00000, SEL0);
        vecs[10] = mk(5'b00101, 5'b11111, 5'b11101, {Z, Z, R3, Z, R3}, 5'b00000, 5'b00000, SEL0);
        vecs[11] = mk(5'b00101, 5'b11111, 5'b11111, {Z, Z, R3, Z, R3}, 5'b00100, 5'b00010, {3'd0, 3'd0, 3'd0, 3'd2, 3'd0});
        vecs[12] = mk(5'b00101, 5'b11111, 5'b11111, {Z, Z, R3, Z, R3}, 5'b00001, 5'b00010, {3'd0, 3'd0, 3'd0, 3'd4, 3'd0});
        // All five inputs to distinct outputs.
        vecs[13] = mk(5'b11111, 5'b11111, 5'b11111, {R1, R2, R3, R4, R0}, 5'b11111, 5'b11111, {3'd4, 3'd0, 3'd1, 3'd2, 3'd3});
        // Multi-hot request reduced to lowest output (1).
        vecs[14] = mk(5'b00010, 5'b11111, 5'b11111, {Z, Z, Z, 5'b01101, Z}, 5'b00010, 5'b01000, {3'd0, 3'd3, 3'd0, 3'd0, 3'd0});
        // U-turn is still arbitrated.
        vecs[15] = mk(5'b00100, 5'b11111, 5'b11111, {Z, Z, R2, Z, Z}, 5'b00100, 5'b00100, {3'd0, 3'd0, 3'd2, 3'd0, 3'd0});
        // Requests without valid are ignored.
        vecs[16] = mk(5'b00000, 5'b11111, 5'b11111, {R0, R0, R0, R0, R0}, 5'b00000, 5'b00000, SEL0);
        // Input 3 locks output 0; owner idle / stalled blocks input 1.
        vecs[17] = mk(5'b00010, 5'b00000, 5'b11111, {Z, Z, Z, R0, Z}, 5'b00010, 5'b10000, {3'd3, 3'd0, 3'd0, 3'd0, 3'd0});
        vecs[18] = mk(5'b01000, 5'b01000, 5'b11111, {Z, R0, Z, Z, Z}, 5'b00000, 5'b00000, SEL0);
        vecs[19] = mk(5'b01010, 5'b01000, 5'b01111, {Z, R0, Z, R0, Z}, 5'b00000, 5'b00000, SEL0);
        vecs[20] = mk(5'b01010, 5'b01010, 5'b11111, {Z, R0, Z, R0, Z}, 5'b00010, 5'b10000, {3'd3, 3'd0, 3'd0, 3'd0, 3'd0});
        vecs[21] = mk(5'b01000, 5'b01000, 5'b11111, {Z, R0, Z, Z, Z}, 5'b01000, 5'b10000, {3'd1, 3'd0, 3'd0, 3'd0, 3'd0});

        // Reset with every input valid and requesting output 2.
        reset_n = 1'b0;
        drive(5'b11111, 5'b11111, 5'b11111, {R2, R2, R2, R2, R2});
        @(negedge clk);
        #2;
        chk_out("reset", 5'b00000, 5'b00000, SEL0);

        @(negedge clk);
        drive(5'b00000, 5'b00000, 5'b11111, {Z, Z, Z, Z, Z});
        reset_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            drive(vecs[k].valid, vecs[k].tail, vecs[k].ready, vecs[k].req);
            #2;
            chk_out($sformatf("v%0d", k), vecs[k].eg, vecs[k].eov, vecs[k].esel);
        end

        // Reset in the middle of a locked packet (ptr[0] is 2 here).
        @(negedge clk);
        drive(5'b10010, 5'b10000, 5'b11111, {R0, Z, Z, R0, Z});
        #2;
        chk_out("mid_head", 5'b00010, 5'b10000, {3'd3, 3'd0, 3'd0, 3'd0, 3'd0});
        @(negedge clk);
        reset_n = 1'b0;
        drive(5'b10011, 5'b10001, 5'b11111, {R0, Z, Z, R0, R0});
        #2;
        chk_out("mid_in_reset", 5'b00000, 5'b00000, SEL0);
        @(negedge clk);
        reset_n = 1'b1;
        #2;
        chk_out("mid_after_reset", 5'b10000, 5'b10000, SEL0);

        @(negedge clk);
        drive(5'b00000, 5'b00000, 5'b11111, {Z, Z, Z, Z, Z});
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
